irq_arbiter: RTL

Interrupt arbiter placed between the user-project interrupt sources and the host-side interrupt path. It latches rising edges of each project's `hi_pri_req` and `user_irq` into per-source pending bits and applies a per-source mask. It arbitrates high-priority first, round-robin within each class, and presents one interrupt at a time to the host through a valid/ack handshake.

---
 rtl/irq_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits per source, per-source mask,
// high-priority-first round-robin arbitration and a valid/ack host handshake.
module irq_arbiter #(
    parameter int unsigned pNUM_SRC  = 4,
    parameter int unsigned pID_WIDTH = 2
) (
    input  logic                 ALCLK,
    input  logic                 ARESET_N,
    input  logic [pNUM_SRC-1:0]  hi_pri_req,
    input  logic [pNUM_SRC-1:0]  user_irq,
    input  logic                 cfg_we,
    input  logic [pNUM_SRC-1:0]  cfg_mask,
    output logic                 irq_valid,
    output logic [pID_WIDTH-1:0] irq_src,
    output logic                 irq_hi,
    input  logic                 irq_ack,
    output logic [pNUM_SRC-1:0]  pend_hi,
    output logic [pNUM_SRC-1:0]  pend_lo
);

    localparam int unsigned N = pNUM_SRC;
    localparam int unsigned W = pID_WIDTH;
    localparam logic [W-1:0] RR_RST = W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Round-robin search beginning one past ptr, wrapping modulo N.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] vec,
                                             input logic [W-1:0] ptr);
        logic [W-1:0] sel;
        logic         found;
        logic [N-1:0] sh;
        int unsigned  idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(ptr) + i) % N;
            sh  = vec >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                sel   = W'(idx);
            end
        end
        return sel;
    endfunction

    logic [N-1:0] r_hi_s;
    logic [N-1:0] r_hi_d;
    logic [N-1:0] r_lo_s;
    logic [N-1:0] r_lo_d;
    logic [N-1:0] r_pend_hi;
    logic [N-1:0] r_pend_lo;
    logic [N-1:0] r_mask;
    logic [W-1:0] r_rr_hi;
    logic [W-1:0] r_rr_lo;
    logic [W-1:0] r_irq_src;
    logic         r_irq_hi;
    logic         r_irq_valid;
    state_t       r_state;

    state_t       w_state_nxt;
    logic         w_load;
    logic [N-1:0] w_rise_hi;
    logic [N-1:0] w_rise_lo;
    logic [N-1:0] w_elig_hi;
    logic [N-1:0] w_elig_lo;
    logic         w_any_hi;
    logic         w_any_lo;
    logic [W-1:0] w_pick_hi;
    logic [W-1:0] w_pick_lo;
    logic [W-1:0] w_gnt_src;
    logic         w_gnt_hi;
    logic         w_hs;
    logic [N-1:0] w_src_vec;
    logic [N-1:0] w_clr_hi;
    logic [N-1:0] w_clr_lo;

    // Inputs are sampled first, then compared with their previous sample.
    assign w_rise_hi = r_hi_s & ~r_hi_d;
    assign w_rise_lo = r_lo_s & ~r_lo_d;

    assign w_elig_hi = r_pend_hi & ~r_mask;
    assign w_elig_lo = r_pend_lo & ~r_mask;
    assign w_any_hi  = |w_elig_hi;
    assign w_any_lo  = |w_elig_lo;
    assign w_pick_hi = rr_pick(w_elig_hi, r_rr_hi);
    assign w_pick_lo = rr_pick(w_elig_lo, r_rr_lo);
    assign w_gnt_src = w_any_hi ? w_pick_hi : w_pick_lo;
    assign w_gnt_hi  = w_any_hi;

    assign w_hs      = (r_state == ST_ISSUE) && irq_ack;
    assign w_src_vec = N'(1) << r_irq_src;
    assign w_clr_hi  = (w_hs && r_irq_hi)  ? w_src_vec : '0;
    assign w_clr_lo  = (w_hs && !r_irq_hi) ? w_src_vec : '0;

    // Input sampling and edge history.
    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_hi_s <= '0;
            r_hi_d <= '0;
            r_lo_s <= '0;
            r_lo_d <= '0;
        end else begin
            r_hi_s <= hi_pri_req;
            r_hi_d <= r_hi_s;
            r_lo_s <= user_irq;
            r_lo_d <= r_lo_s;
        end
    end

    // Pending bits: a new edge wins over a same-cycle clear.
    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_pend_hi <= (r_pend_hi & ~w_clr_hi) | w_rise_hi;
            r_pend_lo <= (r_pend_lo & ~w_clr_lo) | w_rise_lo;
        end
    end

    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_mask <= '0;
        end else if (cfg_we) begin
            r_mask <= cfg_mask;
        end
    end

    // Round-robin pointers follow the last acknowledged source of each class.
    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_rr_hi <= RR_RST;
            r_rr_lo <= RR_RST;
        end else if (w_hs) begin
            if (r_irq_hi) begin
                r_rr_hi <= r_irq_src;
            end else begin
                r_rr_lo <= r_irq_src;
            end
        end
    end

    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_hi || w_any_lo) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (irq_ack) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Presented interrupt is captured once per grant and held until HOLD.
    always_ff @(posedge ALCLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_irq_valid <= 1'b0;
            r_irq_src   <= '0;
            r_irq_hi    <= 1'b0;
        end else begin
            r_irq_valid <= (w_state_nxt == ST_ISSUE);
            if (w_load) begin
                r_irq_src <= w_gnt_src;
                r_irq_hi  <= w_gnt_hi;
            end
        end
    end

    assign irq_valid = r_irq_valid;
    assign irq_src   = r_irq_src;
    assign irq_hi    = r_irq_hi;
    assign pend_hi   = r_pend_hi;
    assign pend_lo   = r_pend_lo;

endmodule
